// File: rtl/csr_trap_sequencer.sv
// rtl/csr_trap_sequencer.sv - trap entry / mret sequencer sharing the CSR file read port and write channels
module csr_trap_sequencer #(
    parameter int CSR_W       = 3,
    parameter int BITS_W      = 64,
    parameter int IDX_MSTATUS = 0,
    parameter int IDX_MTVEC   = 1,
    parameter int IDX_MEPC    = 2,
    parameter int IDX_MCAUSE  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic              trap_is_mret,
    input  logic [BITS_W-1:0] trap_pc,
    input  logic [BITS_W-1:0] trap_cause,
    input  logic              wb_csr_valid,
    output logic              wb_csr_ready,
    input  logic [CSR_W-1:0]  wb_csr_rd,
    input  logic [BITS_W-1:0] wb_csr_data,
    input  logic [CSR_W-1:0]  idu_csr_rs,
    output logic [BITS_W-1:0] idu_csr_rs_data,
    output logic [CSR_W-1:0]  csr_rs,
    input  logic [BITS_W-1:0] csr_rs_data,
    output logic              csr_wr_1,
    output logic [CSR_W-1:0]  csr_rd_1,
    output logic [BITS_W-1:0] csr_bus_w_1,
    output logic              csr_wr_2,
    output logic [CSR_W-1:0]  csr_rd_2,
    output logic [BITS_W-1:0] csr_bus_w_2,
    output logic              redirect_valid,
    output logic [BITS_W-1:0] redirect_pc,
    output logic              busy
);

    localparam logic [CSR_W-1:0]  I_MSTATUS = CSR_W'(IDX_MSTATUS);
    localparam logic [CSR_W-1:0]  I_MTVEC   = CSR_W'(IDX_MTVEC);
    localparam logic [CSR_W-1:0]  I_MEPC    = CSR_W'(IDX_MEPC);
    localparam logic [CSR_W-1:0]  I_MCAUSE  = CSR_W'(IDX_MCAUSE);
    localparam logic [BITS_W-1:0] ALIGN_M   = ~BITS_W'(3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_SAVE = 3'd1,
        T_VEC  = 3'd2,
        R_STAT = 3'd3,
        R_EPC  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [BITS_W-1:0] pc_q;
    logic [BITS_W-1:0] cause_q;
    logic [BITS_W-1:0] status_q;
    logic [BITS_W-1:0] trap_status;
    logic [BITS_W-1:0] mret_status;

    // Trap entry stacks MIE into MPIE; mret restores MIE from MPIE. MPP is forced to M in both.
    always_comb begin
        trap_status        = status_q;
        trap_status[7]     = status_q[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        mret_status        = csr_rs_data;
        mret_status[3]     = csr_rs_data[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            status_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && trap_valid) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
            end
            if (state == T_SAVE) begin
                status_q <= csr_rs_data;
            end
        end
    end

    always_comb begin
        state_n         = state;
        trap_ready      = 1'b0;
        wb_csr_ready    = 1'b0;
        idu_csr_rs_data = '0;
        csr_rs          = '0;
        csr_wr_1        = 1'b0;
        csr_rd_1        = '0;
        csr_bus_w_1     = '0;
        csr_wr_2        = 1'b0;
        csr_rd_2        = '0;
        csr_bus_w_2     = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        busy            = 1'b1;
        case (state)
            IDLE: begin
                busy            = 1'b0;
                csr_rs          = idu_csr_rs;
                idu_csr_rs_data = csr_rs_data;
                if (trap_valid) begin
                    trap_ready = 1'b1;
                    state_n    = trap_is_mret ? R_STAT : T_SAVE;
                end else if (wb_csr_valid) begin
                    wb_csr_ready = 1'b1;
                    csr_wr_1     = 1'b1;
                    csr_rd_1     = wb_csr_rd;
                    csr_bus_w_1  = wb_csr_data;
                end
            end
            T_SAVE: begin
                csr_wr_1    = 1'b1;
                csr_rd_1    = I_MEPC;
                csr_bus_w_1 = pc_q & ALIGN_M;
                csr_wr_2    = 1'b1;
                csr_rd_2    = I_MCAUSE;
                csr_bus_w_2 = cause_q;
                csr_rs      = I_MSTATUS;
                state_n     = T_VEC;
            end
            T_VEC: begin
                csr_wr_1       = 1'b1;
                csr_rd_1       = I_MSTATUS;
                csr_bus_w_1    = trap_status;
                csr_rs         = I_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rs_data & ALIGN_M;
                state_n        = IDLE;
            end
            R_STAT: begin
                csr_rs      = I_MSTATUS;
                csr_wr_1    = 1'b1;
                csr_rd_1    = I_MSTATUS;
                csr_bus_w_1 = mret_status;
                state_n     = R_EPC;
            end
            R_EPC: begin
                csr_rs         = I_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rs_data;
                state_n        = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Nothing may leave the block during the reset cycle, whatever state it was in.
        if (rst) begin
            trap_ready     = 1'b0;
            wb_csr_ready   = 1'b0;
            csr_wr_1       = 1'b0;
            csr_rd_1       = '0;
            csr_bus_w_1    = '0;
            csr_wr_2       = 1'b0;
            csr_rd_2       = '0;
            csr_bus_w_2    = '0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            busy           = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb/tb_csr_trap_sequencer.sv - directed and randomized bench with a CSR-file reference model
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, trap_ready, trap_is_mret;
    logic [63:0] trap_pc, trap_cause;
    logic        wb_csr_valid, wb_csr_ready;
    logic [2:0]  wb_csr_rd;
    logic [63:0] wb_csr_data;
    logic [2:0]  idu_csr_rs;
    logic [63:0] idu_csr_rs_data;
    logic [2:0]  csr_rs;
    logic [63:0] csr_rs_data;
    logic        csr_wr_1, csr_wr_2;
    logic [2:0]  csr_rd_1, csr_rd_2;
    logic [63:0] csr_bus_w_1, csr_bus_w_2;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    logic        pre_en;
    logic [2:0]  pre_idx;
    logic [63:0] pre_val;
    logic [63:0] mem [8];
    logic [63:0] ref_csr [8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .clk(clk), .rst(rst),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_is_mret(trap_is_mret),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .wb_csr_valid(wb_csr_valid), .wb_csr_ready(wb_csr_ready),
        .wb_csr_rd(wb_csr_rd), .wb_csr_data(wb_csr_data),
        .idu_csr_rs(idu_csr_rs), .idu_csr_rs_data(idu_csr_rs_data),
        .csr_rs(csr_rs), .csr_rs_data(csr_rs_data),
        .csr_wr_1(csr_wr_1), .csr_rd_1(csr_rd_1), .csr_bus_w_1(csr_bus_w_1),
        .csr_wr_2(csr_wr_2), .csr_rd_2(csr_rd_2), .csr_bus_w_2(csr_bus_w_2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    // CSR file: combinational read, two write ports, plus a preload port for the bench
    assign csr_rs_data = mem[csr_rs];
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else begin
            if (csr_wr_1) mem[csr_rd_1] <= csr_bus_w_1;
            if (csr_wr_2) mem[csr_rd_2] <= csr_bus_w_2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] after_trap(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        r[7] = s[3];
        r[3] = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [63:0] after_mret(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        r[3] = s[7];
        r[7] = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic quiet();
        trap_valid = 1'b0;
        trap_is_mret = 1'b0;
        wb_csr_valid = 1'b0;
        trap_pc = rnd64();
        trap_cause = rnd64();
    endtask

    task automatic preload(input logic [2:0] idx, input logic [63:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        ref_csr[idx] = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] idx);
        @(negedge clk);
        quiet();
        idu_csr_rs = idx;
        #1;
        chk("rd_data", idu_csr_rs_data, ref_csr[idx]);
        chk("rd_busy", 64'(busy), 0);
        chk("rd_wr1", 64'(csr_wr_1), 0);
        chk("rd_wr2", 64'(csr_wr_2), 0);
        chk("rd_redir", 64'(redirect_valid), 0);
    endtask

    task automatic do_wb(input logic [2:0] rd, input logic [63:0] data);
        @(negedge clk);
        quiet();
        wb_csr_valid = 1'b1; wb_csr_rd = rd; wb_csr_data = data;
        #1;
        chk("wb_ready", 64'(wb_csr_ready), 1);
        chk("wb_wr1", 64'(csr_wr_1), 1);
        chk("wb_rd1", 64'(csr_rd_1), 64'(rd));
        chk("wb_bus1", csr_bus_w_1, data);
        chk("wb_wr2", 64'(csr_wr_2), 0);
        ref_csr[rd] = data;
    endtask

    task automatic do_trap(input logic [63:0] pc, input logic [63:0] cause,
                           input bit with_wb, input logic [2:0] wrd, input logic [63:0] wdat);
        logic [63:0] exp_stat;
        @(negedge clk);
        quiet();
        trap_valid = 1'b1; trap_pc = pc; trap_cause = cause;
        wb_csr_valid = with_wb; wb_csr_rd = wrd; wb_csr_data = wdat;
        #1;
        chk("tacc_ready", 64'(trap_ready), 1);
        chk("tacc_wbrdy", 64'(wb_csr_ready), 0);
        chk("tacc_wr1", 64'(csr_wr_1), 0);
        chk("tacc_wr2", 64'(csr_wr_2), 0);
        @(negedge clk);
        trap_valid = 1'b0; trap_pc = rnd64(); trap_cause = rnd64();
        #1;
        chk("tsave_busy", 64'(busy), 1);
        chk("tsave_ready", 64'(trap_ready | wb_csr_ready), 0);
        chk("tsave_idu", idu_csr_rs_data, 0);
        chk("tsave_wr1", 64'(csr_wr_1), 1);
        chk("tsave_rd1", 64'(csr_rd_1), 2);
        chk("tsave_epc", csr_bus_w_1, {pc[63:2], 2'b00});
        chk("tsave_wr2", 64'(csr_wr_2), 1);
        chk("tsave_rd2", 64'(csr_rd_2), 3);
        chk("tsave_cause", csr_bus_w_2, cause);
        chk("tsave_redir", 64'(redirect_valid), 0);
        ref_csr[2] = {pc[63:2], 2'b00};
        ref_csr[3] = cause;
        exp_stat = after_trap(ref_csr[0]);
        @(negedge clk);
        #1;
        chk("tvec_busy", 64'(busy), 1);
        chk("tvec_wr1", 64'(csr_wr_1), 1);
        chk("tvec_rd1", 64'(csr_rd_1), 0);
        chk("tvec_stat", csr_bus_w_1, exp_stat);
        chk("tvec_wr2", 64'(csr_wr_2), 0);
        chk("tvec_redir", 64'(redirect_valid), 1);
        chk("tvec_pc", redirect_pc, {ref_csr[1][63:2], 2'b00});
        ref_csr[0] = exp_stat;
        @(negedge clk);
        #1;
        chk("tpost_redir", 64'(redirect_valid), 0);
        chk("tpost_busy", 64'(busy), 0);
        if (with_wb) begin
            chk("tpost_wbrdy", 64'(wb_csr_ready), 1);
            chk("tpost_wr1", 64'(csr_wr_1), 1);
            chk("tpost_rd1", 64'(csr_rd_1), 64'(wrd));
            chk("tpost_bus1", csr_bus_w_1, wdat);
            ref_csr[wrd] = wdat;
        end else begin
            chk("tpost_wr1", 64'(csr_wr_1), 0);
        end
    endtask

    task automatic do_mret();
        logic [63:0] exp_stat;
        @(negedge clk);
        quiet();
        trap_valid = 1'b1; trap_is_mret = 1'b1;
        #1;
        chk("macc_ready", 64'(trap_ready), 1);
        chk("macc_wr1", 64'(csr_wr_1), 0);
        @(negedge clk);
        trap_valid = 1'b0; trap_is_mret = 1'b0;
        #1;
        exp_stat = after_mret(ref_csr[0]);
        chk("mstat_busy", 64'(busy), 1);
        chk("mstat_wr1", 64'(csr_wr_1), 1);
        chk("mstat_rd1", 64'(csr_rd_1), 0);
        chk("mstat_val", csr_bus_w_1, exp_stat);
        chk("mstat_wr2", 64'(csr_wr_2), 0);
        chk("mstat_redir", 64'(redirect_valid), 0);
        ref_csr[0] = exp_stat;
        @(negedge clk);
        #1;
        chk("mepc_busy", 64'(busy), 1);
        chk("mepc_wr1", 64'(csr_wr_1), 0);
        chk("mepc_redir", 64'(redirect_valid), 1);
        chk("mepc_pc", redirect_pc, ref_csr[2]);
        @(negedge clk);
        #1;
        chk("mpost_redir", 64'(redirect_valid), 0);
        chk("mpost_busy", 64'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        idu_csr_rs = '0; wb_csr_rd = '0; wb_csr_data = '0;
        quiet();
        trap_valid = 1'b1; wb_csr_valid = 1'b1;
        for (int i = 0; i < 8; i++) preload(3'(i), 64'(i) * 64'h1111);
        preload(3'd0, 64'ha_0000_1808);
        preload(3'd1, 64'h8000_0000);
        #1;
        chk("rst_trap_ready", 64'(trap_ready), 0);
        chk("rst_wb_ready", 64'(wb_csr_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wr", 64'({csr_wr_1, csr_wr_2, redirect_valid}), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet();

        do_read(3'd1);
        do_wb(3'd1, 64'h8000_0100);
        do_trap(64'h8000_0010, 64'd11, 1'b0, 3'd0, 64'd0);
        chk("plan_mstatus", ref_csr[0], 64'ha_0000_1880);
        do_mret();
        chk("plan_mret_stat", ref_csr[0], 64'ha_0000_1888);
        do_trap(64'h8000_0203, 64'd2, 1'b1, 3'd5, 64'h1234_5678_9abc_def0);

        // reset while in T_SAVE: nothing further is written or redirected
        @(negedge clk);
        quiet();
        trap_valid = 1'b1; trap_pc = 64'h9000_0000; trap_cause = 64'd7;
        #1;
        chk("rsv_ready", 64'(trap_ready), 1);
        @(negedge clk);
        quiet();
        rst = 1'b1;
        #1;
        chk("rsv_wr", 64'({csr_wr_1, csr_wr_2}), 0);
        chk("rsv_redir", 64'(redirect_valid), 0);
        chk("rsv_busy", 64'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rsv_post_busy", 64'(busy), 0);
        chk("rsv_post_wr", 64'({csr_wr_1, csr_wr_2}), 0);
        chk("rsv_post_redir", 64'(redirect_valid), 0);
        do_read(3'd2);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: do_read(3'($urandom_range(0, 7)));
                1: do_wb(3'($urandom_range(0, 7)), rnd64());
                2: do_trap(rnd64(), rnd64(), 1'b0, 3'd0, 64'd0);
                3: do_mret();
                default: do_trap(rnd64(), rnd64(), 1'b1, 3'($urandom_range(0, 7)), rnd64());
            endcase
        end

        @(negedge clk);
        quiet();
        for (int i = 0; i < 8; i++) chk("final_csr", mem[i], ref_csr[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
